// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, oversampling constants and word-length codes.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int OSM13_N    = 13;
    localparam int OSM16_N    = 16;
    localparam int OSM13_HALF = 6;
    localparam int OSM16_HALF = 8;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    // Terminal count of the 4-bit tick counter: a full bit period, or half of one for the start bit.
    function automatic logic [3:0] tick_last_val(input logic osm13, input logic half);
        int v;
        if (half)
            v = osm13 ? OSM13_HALF : OSM16_HALF;
        else
            v = osm13 ? OSM13_N : OSM16_N;
        return 4'(v - 1);
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst)
            ff <= '1;
        else
            ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: oversampled start/data/parity/stop decode with parity, framing and break flags.
//  state     | meaning
//  ST_IDLE   | waiting for a falling edge on an armed line
//  ST_START  | counting to mid start bit, false starts drop back to idle
//  ST_DATA   | sampling 5..8 data bits, LSB first
//  ST_PARITY | sampling the parity bit
//  ST_STOP   | sampling the first stop bit, then reporting the frame
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       OSM_SEL,
    input  logic       rx_tick,
    input  logic       rxd,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       pe,
    output logic       fe,
    output logic       be,
    output logic       rx_busy
);

    uart_state_t state, state_nxt;

    logic       rxd_s;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       cfg_osm;
    logic [1:0] cfg_wls;
    logic       cfg_pen;
    logic       cfg_eps;
    logic       par_acc;
    logic       all_zero;
    logic       pe_frame;
    logic       armed;
    logic       tick_last;
    logic       sample;
    logic       start_go;

    rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign tick_last = (tick_cnt == tick_last_val(cfg_osm, state == ST_START));
    assign sample    = rx_tick & tick_last;
    assign start_go  = en & ~rxd_s & armed;
    assign rx_busy   = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_go) state_nxt = ST_START;
            ST_START:  if (sample) state_nxt = rxd_s ? ST_IDLE : ST_DATA;
            ST_DATA:   if (sample && bit_cnt == {1'b1, cfg_wls})
                           state_nxt = cfg_pen ? ST_PARITY : ST_STOP;
            ST_PARITY: if (sample) state_nxt = ST_STOP;
            ST_STOP:   if (sample) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        if (!en)
            state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            cfg_osm  <= 1'b0;
            cfg_wls  <= WLS_5;
            cfg_pen  <= 1'b0;
            cfg_eps  <= 1'b0;
            par_acc  <= 1'b0;
            all_zero <= 1'b0;
            pe_frame <= 1'b0;
            armed    <= 1'b1;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            pe       <= 1'b0;
            fe       <= 1'b0;
            be       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (rxd_s)
                armed <= 1'b1;
            if (state == ST_IDLE) begin
                if (start_go) begin
                    tick_cnt <= '0;
                    bit_cnt  <= '0;
                    shreg    <= '0;
                    par_acc  <= 1'b0;
                    all_zero <= 1'b1;
                    pe_frame <= 1'b0;
                    cfg_osm  <= OSM_SEL;
                    cfg_wls  <= wls;
                    cfg_pen  <= pen;
                    cfg_eps  <= eps;
                end
            end else if (en && rx_tick) begin
                tick_cnt <= tick_last ? 4'd0 : tick_cnt + 4'd1;
                if (tick_last) begin
                    case (state)
                        ST_DATA: begin
                            shreg[bit_cnt] <= rxd_s;
                            bit_cnt        <= bit_cnt + 3'd1;
                            par_acc        <= par_acc ^ rxd_s;
                            all_zero       <= all_zero & ~rxd_s;
                        end
                        ST_PARITY: begin
                            pe_frame <= cfg_eps ? (par_acc ^ rxd_s) : ~(par_acc ^ rxd_s);
                            all_zero <= all_zero & ~rxd_s;
                        end
                        // A low stop sample on a break line must not restart until the line idles.
                        ST_STOP: begin
                            rx_valid <= 1'b1;
                            rx_data  <= shreg;
                            pe       <= pe_frame;
                            fe       <= ~rxd_s;
                            be       <= all_zero & ~rxd_s;
                            armed    <= 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: table of frames plus abort, break and false-start sequences.
module tb_uart_rx_frame;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       be;
    } res_t;

    typedef struct packed {
        logic       osm;
        logic [1:0] wls;
        logic       pen;
        logic       eps;
        logic [7:0] din;
        logic       par;
        logic       stop;
        res_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       OSM_SEL = 1'b0;
    logic       rx_tick = 1'b0;
    logic       rxd = 1'b1;
    logic [1:0] wls = 2'b11;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       pe;
    logic       fe;
    logic       be;
    logic       rx_busy;

    int   n_checks = 0;
    int   n_fail = 0;
    int   n_valid = 0;
    res_t exp_q[$];
    logic [1:0] tdiv = 2'd0;
    vec_t vecs[10];

    uart_rx_frame #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .OSM_SEL  (OSM_SEL),
        .rx_tick  (rx_tick),
        .rxd      (rxd),
        .wls      (wls),
        .pen      (pen),
        .eps      (eps),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .pe       (pe),
        .fe       (fe),
        .be       (be),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tdiv    <= tdiv + 2'd1;
        rx_tick <= (tdiv == 2'd3);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid) begin
            res_t got;
            res_t want;
            n_valid++;
            got = '{rx_data, pe, fe, be};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rx_valid: got %0h expected none", got);
            end else begin
                want = exp_q.pop_front();
                check("frame_result", 32'(got), 32'(want));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic hold_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!rx_tick) @(posedge clk);
        end
        #1;
    endtask

    // evt_kind: 0 none, 1 reset at mid bit evt_bit, 2 enable drop at mid bit, 3 config change at bit
    task automatic send_frame(input logic osm, input logic [1:0] w, input logic p, input logic e,
                              input logic [7:0] d, input logic par, input logic stop,
                              input int evt_bit, input int evt_kind);
        int n;
        int nb;
        n  = osm ? 13 : 16;
        nb = 5 + int'(w);
        OSM_SEL = osm;
        wls = w;
        pen = p;
        eps = e;
        hold_ticks(1);
        rxd = 1'b0;
        hold_ticks(n);
        for (int i = 0; i < nb; i++) begin
            if (i == evt_bit && evt_kind == 3) begin
                OSM_SEL = ~osm;
                wls = ~w;
                pen = ~p;
                eps = ~e;
            end
            rxd = d[i];
            if (i == evt_bit && (evt_kind == 1 || evt_kind == 2)) begin
                hold_ticks(n / 2);
                rxd = 1'b1;
                if (evt_kind == 1) begin
                    @(posedge clk); #1 rst = 1'b1;
                    @(posedge clk); #1 rst = 1'b0;
                end else begin
                    en = 1'b0;
                    @(posedge clk); #1;
                    @(posedge clk); #1 en = 1'b1;
                end
                hold_ticks(3 * n);
                return;
            end
            hold_ticks(n);
        end
        if (p) begin
            rxd = par;
            hold_ticks(n);
        end
        rxd = stop;
        hold_ticks(n);
        rxd = 1'b1;
        hold_ticks(2 * n);
    endtask

    initial begin
        int v0;

        vecs[0] = '{1'b0, 2'd3, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, '{8'h5A, 1'b0, 1'b0, 1'b0}};
        vecs[1] = '{1'b1, 2'd0, 1'b1, 1'b1, 8'h13, 1'b0, 1'b1, '{8'h13, 1'b1, 1'b0, 1'b0}};
        vecs[2] = '{1'b0, 2'd3, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, '{8'hFF, 1'b0, 1'b0, 1'b0}};
        vecs[3] = '{1'b0, 2'd1, 1'b0, 1'b0, 8'h2C, 1'b0, 1'b0, '{8'h2C, 1'b0, 1'b1, 1'b0}};
        vecs[4] = '{1'b1, 2'd2, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, '{8'h55, 1'b1, 1'b0, 1'b0}};
        vecs[5] = '{1'b0, 2'd3, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, '{8'h00, 1'b0, 1'b1, 1'b1}};
        vecs[6] = '{1'b0, 2'd0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, '{8'h1F, 1'b0, 1'b0, 1'b0}};
        vecs[7] = '{1'b1, 2'd3, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, '{8'hA5, 1'b0, 1'b0, 1'b0}};
        vecs[8] = '{1'b1, 2'd1, 1'b1, 1'b0, 8'h3F, 1'b1, 1'b1, '{8'h3F, 1'b0, 1'b0, 1'b0}};
        vecs[9] = '{1'b0, 2'd3, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, '{8'h00, 1'b1, 1'b1, 1'b0}};

        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_rx_valid", 32'(rx_valid), 32'h0);
        check("reset_pe", 32'(pe), 32'h0);
        check("reset_fe", 32'(fe), 32'h0);
        check("reset_be", 32'(be), 32'h0);
        check("reset_rx_busy", 32'(rx_busy), 32'h0);
        rst = 1'b0;
        hold_ticks(4);

        for (int k = 0; k < 10; k++) begin
            v0 = n_valid;
            exp_q.push_back(vecs[k].exp);
            send_frame(vecs[k].osm, vecs[k].wls, vecs[k].pen, vecs[k].eps,
                       vecs[k].din, vecs[k].par, vecs[k].stop, -1, 0);
            check($sformatf("vec%0d_valid_count", k), 32'(n_valid - v0), 32'd1);
            check($sformatf("vec%0d_busy_idle", k), 32'(rx_busy), 32'h0);
        end

        // false start: low for 4 ticks, decision on the 8th
        v0 = n_valid;
        OSM_SEL = 1'b0;
        hold_ticks(1);
        rxd = 1'b0;
        hold_ticks(4);
        rxd = 1'b1;
        hold_ticks(2);
        check("false_start_busy_mid", 32'(rx_busy), 32'h1);
        hold_ticks(2);
        check("false_start_busy_after", 32'(rx_busy), 32'h0);
        hold_ticks(20);
        check("false_start_no_valid", 32'(n_valid - v0), 32'd0);

        // break: two frame times low gives one frame only
        v0 = n_valid;
        OSM_SEL = 1'b0;
        wls = 2'd3;
        pen = 1'b1;
        eps = 1'b1;
        exp_q.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
        hold_ticks(1);
        rxd = 1'b0;
        hold_ticks(352);
        check("break_one_valid_while_low", 32'(n_valid - v0), 32'd1);
        check("break_busy_while_low", 32'(rx_busy), 32'h0);
        rxd = 1'b1;
        hold_ticks(48);
        check("break_total_valid", 32'(n_valid - v0), 32'd1);

        // reset mid-frame, then a clean frame
        v0 = n_valid;
        send_frame(1'b0, 2'd3, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 3, 1);
        check("rst_abort_no_valid", 32'(n_valid - v0), 32'd0);
        check("rst_abort_rx_data", 32'(rx_data), 32'h00);
        check("rst_abort_busy", 32'(rx_busy), 32'h0);
        exp_q.push_back('{8'h3C, 1'b0, 1'b0, 1'b0});
        send_frame(1'b0, 2'd3, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, -1, 0);
        check("after_rst_one_valid", 32'(n_valid - v0), 32'd1);

        // enable drop mid-frame: discarded, outputs hold
        v0 = n_valid;
        send_frame(1'b0, 2'd3, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 3, 2);
        check("en_abort_no_valid", 32'(n_valid - v0), 32'd0);
        check("en_abort_rx_data_held", 32'(rx_data), 32'h3C);
        check("en_abort_busy", 32'(rx_busy), 32'h0);

        // configuration toggled mid-frame has no effect
        v0 = n_valid;
        exp_q.push_back('{8'hC3, 1'b0, 1'b0, 1'b0});
        send_frame(1'b0, 2'd3, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 2, 3);
        check("cfg_toggle_one_valid", 32'(n_valid - v0), 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
